// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
//   Shared types and defaults for the calculator command sequencer.
//   cmd_t    : keypad command codes (digits 0-9 are plain values below CMD_ADD)
//   status_t : display status reported to calc_top
//   state_t  : sequencer states
//   Helpers  : is_digit / is_arith_op command classifiers
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam int CALC_DIGITS = 8;
    localparam int CALC_WIDTH  = 27;

    typedef enum logic [3:0] {
        CMD_ADD = 4'hA,
        CMD_SUB = 4'hB,
        CMD_MUL = 4'hC,
        CMD_RSV = 4'hD,
        CMD_EQ  = 4'hE,
        CMD_CLR = 4'hF
    } cmd_t;

    typedef enum logic [1:0] {
        ST_EDIT   = 2'b00,
        ST_BUSY   = 2'b01,
        ST_ERROR  = 2'b10,
        ST_RESULT = 2'b11
    } status_t;

    typedef enum logic [2:0] {
        S_OP1    = 3'd0,
        S_OP2    = 3'd1,
        S_MUL    = 3'd2,
        S_RESULT = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

    function automatic logic is_arith_op(input logic [3:0] code);
        return (code == CMD_ADD) || (code == CMD_SUB) || (code == CMD_MUL);
    endfunction

endpackage

// File: rtl/calc_mul_seq.sv
// -----------------------------------------------------------------------------
// calc_mul_seq
//   Iterative shift-add multiplier, one multiplier bit per cycle.
//   The first partial product is folded in on the start edge, so the final
//   product is registered and done pulses exactly WIDTH-1 edges after start,
//   letting the controller leave its busy state WIDTH cycles after start.
// Ports
//   clock    in   1          clock
//   reset    in   1          synchronous, active-high
//   start    in   1          load operands and begin (1-cycle strobe)
//   abort    in   1          drop any multiplication in progress
//   a, b     in   WIDTH      multiplicand / multiplier
//   done     out  1          1-cycle pulse, product valid while high
//   product  out  2*WIDTH    full-width product
// -----------------------------------------------------------------------------
module calc_mul_seq
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      cnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [2*WIDTH-1:0] a_ext;

    assign a_ext = {{WIDTH{1'b0}}, a};

    always_ff @(posedge clock) begin
        if (reset || abort) begin
            mcand_reg  <= '0;
            prod_reg   <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                // Bit 0 of the multiplier is consumed here; WIDTH-1 bits remain.
                prod_reg   <= b[0] ? a_ext : '0;
                mcand_reg  <= a_ext << 1;
                mplier_reg <= b >> 1;
                cnt_reg    <= CW'(WIDTH - 1);
                busy_reg   <= 1'b1;
            end else if (busy_reg) begin
                if (mplier_reg[0]) begin
                    prod_reg <= prod_reg + mcand_reg;
                end
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg - 1'b1;
                if (cnt_reg == CW'(1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done    = done_reg;
    assign product = prod_reg;

endmodule

// File: rtl/calc_ctrl.sv
// -----------------------------------------------------------------------------
// calc_ctrl
//   Command sequencer for the calculator core. Accepts one keypad command per
//   cmd_valid cycle, accumulates decimal operands in binary, performs add/sub
//   in one cycle and hands multiplication to calc_mul_seq.
// Ports
//   clock      in   1      clock
//   reset      in   1      synchronous, active-high
//   cmd        in   4      command code (digit 0-9 or calc_pkg::cmd_t)
//   cmd_valid  in   1      cmd is sampled only when high
//   value      out  WIDTH  magnitude to display
//   neg        out  1      display a minus sign
//   status     out  2      EDIT / BUSY / ERROR / RESULT
// -----------------------------------------------------------------------------
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int DIGITS = CALC_DIGITS,
    parameter int WIDTH  = CALC_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       cmd,
    input  logic             cmd_valid,
    output logic [WIDTH-1:0] value,
    output logic             neg,
    output logic [1:0]       status
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0]    DIGITS_C = CW'(DIGITS);
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(10**DIGITS - 1);

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] acc_reg,    acc_next;
    logic [WIDTH-1:0] op1_reg,    op1_next;
    logic [WIDTH-1:0] result_reg, result_next;
    cmd_t             pend_reg,   pend_next;
    logic [CW-1:0]    count_reg,  count_next;
    logic             seen_reg,   seen_next;   // a digit of operand 2 has been typed
    logic             neg_reg,    neg_next;
    logic [WIDTH-1:0] value_reg,  value_next;
    status_t          status_reg, status_next;

    logic               cmd_digit;
    logic               cmd_op;
    logic               cmd_eq;
    logic               cmd_clr;
    logic [WIDTH-1:0]   digit_ext;
    logic [WIDTH-1:0]   acc_shifted;
    logic [WIDTH:0]     sum;
    logic               sub_neg;
    logic [WIDTH-1:0]   diff;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign cmd_digit = cmd_valid && is_digit(cmd);
    assign cmd_op    = cmd_valid && is_arith_op(cmd);
    assign cmd_eq    = cmd_valid && (cmd == CMD_EQ);
    assign cmd_clr   = cmd_valid && (cmd == CMD_CLR);

    // acc*10 + d without a multiplier: (acc<<3) + (acc<<1) + d.
    assign digit_ext   = {{(WIDTH-4){1'b0}}, cmd};
    assign acc_shifted = (acc_reg << 3) + (acc_reg << 1) + digit_ext;

    assign sum     = {1'b0, op1_reg} + {1'b0, acc_reg};
    assign sub_neg = (op1_reg < acc_reg);
    assign diff    = sub_neg ? (acc_reg - op1_reg) : (op1_reg - acc_reg);

    calc_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .abort   (cmd_clr),
        .a       (op1_reg),
        .b       (acc_reg),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= S_OP1;
            acc_reg    <= '0;
            op1_reg    <= '0;
            result_reg <= '0;
            pend_reg   <= CMD_ADD;
            count_reg  <= '0;
            seen_reg   <= 1'b0;
            neg_reg    <= 1'b0;
            value_reg  <= '0;
            status_reg <= ST_EDIT;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            op1_reg    <= op1_next;
            result_reg <= result_next;
            pend_reg   <= pend_next;
            count_reg  <= count_next;
            seen_reg   <= seen_next;
            neg_reg    <= neg_next;
            value_reg  <= value_next;
            status_reg <= status_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        op1_next    = op1_reg;
        result_next = result_reg;
        pend_next   = pend_reg;
        count_next  = count_reg;
        seen_next   = seen_reg;
        neg_next    = neg_reg;
        mul_start   = 1'b0;

        if (cmd_clr) begin
            state_next  = S_OP1;
            acc_next    = '0;
            op1_next    = '0;
            result_next = '0;
            pend_next   = CMD_ADD;
            count_next  = '0;
            seen_next   = 1'b0;
            neg_next    = 1'b0;
        end else begin
            unique case (state_reg)
                S_OP1, S_OP2: begin
                    if (cmd_digit) begin
                        // Digits beyond DIGITS are silently dropped.
                        if (count_reg < DIGITS_C) begin
                            acc_next   = acc_shifted;
                            count_next = count_reg + 1'b1;
                            seen_next  = 1'b1;
                        end
                    end else if (cmd_op) begin
                        pend_next = cmd_t'(cmd);
                        if (state_reg == S_OP1) begin
                            op1_next   = acc_reg;
                            acc_next   = '0;
                            count_next = '0;
                            seen_next  = 1'b0;
                            state_next = S_OP2;
                        end
                    end else if (cmd_eq && (state_reg == S_OP2)) begin
                        unique case (pend_reg)
                            CMD_ADD: begin
                                neg_next = 1'b0;
                                if (sum > {1'b0, MAX_VAL}) begin
                                    state_next = S_ERR;
                                end else begin
                                    result_next = sum[WIDTH-1:0];
                                    state_next  = S_RESULT;
                                end
                            end
                            CMD_SUB: begin
                                result_next = diff;
                                neg_next    = sub_neg;
                                state_next  = S_RESULT;
                            end
                            default: begin
                                mul_start  = 1'b1;
                                neg_next   = 1'b0;
                                state_next = S_MUL;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    // Commands other than CLR are dropped while busy.
                    if (mul_done) begin
                        if (mul_product > {{WIDTH{1'b0}}, MAX_VAL}) begin
                            state_next = S_ERR;
                        end else begin
                            result_next = mul_product[WIDTH-1:0];
                            state_next  = S_RESULT;
                        end
                    end
                end
                S_RESULT: begin
                    if (cmd_digit) begin
                        acc_next   = digit_ext;
                        count_next = CW'(1);
                        seen_next  = 1'b1;
                        neg_next   = 1'b0;
                        state_next = S_OP1;
                    end else if (cmd_op && !neg_reg) begin
                        // Chaining: the shown result becomes operand 1.
                        op1_next   = result_reg;
                        pend_next  = cmd_t'(cmd);
                        acc_next   = '0;
                        count_next = '0;
                        seen_next  = 1'b0;
                        state_next = S_OP2;
                    end
                end
                S_ERR: begin
                    neg_next = 1'b0;
                end
                default: begin
                    state_next = S_OP1;
                end
            endcase
        end
    end

    // Outputs are derived from the next-state values so they are registered
    // yet still reflect a command on the edge that accepts it.
    always_comb begin
        value_next  = '0;
        status_next = ST_EDIT;
        unique case (state_next)
            S_OP1:    value_next = acc_next;
            S_OP2:    value_next = seen_next ? acc_next : op1_next;
            S_MUL: begin
                value_next  = op1_next;
                status_next = ST_BUSY;
            end
            S_RESULT: begin
                value_next  = result_next;
                status_next = ST_RESULT;
            end
            S_ERR:    status_next = ST_ERROR;
            default:  status_next = ST_EDIT;
        endcase
    end

    assign value  = value_reg;
    assign neg    = neg_reg;
    assign status = status_reg;

endmodule

// File: tb/tb_calc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_calc_ctrl
//   Drives directed keypad sequences and a randomized command stream into
//   calc_ctrl and compares value/neg/status every cycle against an
//   arithmetic reference model of the calculator's behaviour.
// -----------------------------------------------------------------------------
module tb_calc_ctrl;
    import calc_pkg::*;

    localparam int     W    = CALC_WIDTH;
    localparam longint MAXV = 64'd99999999;

    // Model modes: what the calculator is doing from the user's point of view.
    localparam int M_ENTER1 = 0;
    localparam int M_ENTER2 = 1;
    localparam int M_BUSY   = 2;
    localparam int M_RESULT = 3;
    localparam int M_ERROR  = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   cmd;
    logic         cmd_valid;
    logic [W-1:0] value;
    logic         neg;
    logic [1:0]   status;

    always #5 clock = ~clock;

    calc_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .value     (value),
        .neg       (neg),
        .status    (status)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int     m_mode;
    longint m_acc, m_op1, m_res, m_prod;
    int     m_cnt;
    bit     m_seen, m_neg;
    int     m_pend;
    int     m_left;

    function automatic void m_clear();
        m_mode = M_ENTER1;
        m_acc = 0; m_op1 = 0; m_res = 0; m_prod = 0;
        m_cnt = 0; m_seen = 0; m_neg = 0; m_pend = 10; m_left = 0;
    endfunction

    function automatic void m_step(input bit v, input int c);
        if (v && c == 15) begin
            m_clear();
            return;
        end
        if (m_mode == M_BUSY) begin
            m_left--;
            if (m_left == 0) begin
                if (m_prod > MAXV) m_mode = M_ERROR;
                else begin
                    m_res  = m_prod;
                    m_mode = M_RESULT;
                end
            end
            return;
        end
        if (!v) return;
        if (m_mode == M_ENTER1 || m_mode == M_ENTER2) begin
            if (c <= 9) begin
                if (m_cnt < 8) begin
                    m_acc = m_acc * 10 + c;
                    m_cnt++;
                    m_seen = 1;
                end
            end else if (c >= 10 && c <= 12) begin
                if (m_mode == M_ENTER1) begin
                    m_op1 = m_acc; m_acc = 0; m_cnt = 0; m_seen = 0;
                    m_mode = M_ENTER2;
                end
                m_pend = c;
            end else if (c == 14 && m_mode == M_ENTER2) begin
                m_neg = 0;
                if (m_pend == 10) begin
                    if (m_op1 + m_acc > MAXV) m_mode = M_ERROR;
                    else begin
                        m_res = m_op1 + m_acc;
                        m_mode = M_RESULT;
                    end
                end else if (m_pend == 11) begin
                    m_neg  = (m_op1 < m_acc);
                    m_res  = m_neg ? m_acc - m_op1 : m_op1 - m_acc;
                    m_mode = M_RESULT;
                end else begin
                    m_prod = m_op1 * m_acc;
                    m_left = W;
                    m_mode = M_BUSY;
                end
            end
        end else if (m_mode == M_RESULT) begin
            if (c <= 9) begin
                m_acc = c; m_cnt = 1; m_seen = 1; m_neg = 0;
                m_mode = M_ENTER1;
            end else if (c >= 10 && c <= 12 && !m_neg) begin
                m_op1 = m_res; m_pend = c; m_acc = 0; m_cnt = 0; m_seen = 0;
                m_mode = M_ENTER2;
            end
        end
    endfunction

    function automatic longint m_value();
        case (m_mode)
            M_ENTER1: return m_acc;
            M_ENTER2: return m_seen ? m_acc : m_op1;
            M_BUSY:   return m_op1;
            M_RESULT: return m_res;
            default:  return 0;
        endcase
    endfunction

    function automatic int m_status();
        case (m_mode)
            M_BUSY:   return 1;
            M_ERROR:  return 2;
            M_RESULT: return 3;
            default:  return 0;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input logic v, input logic [3:0] c);
        @(negedge clock);
        cmd_valid = v;
        cmd       = c;
        @(posedge clock);
        m_step(v, int'(c));
        #1;
        chk("value",  64'(value),  64'(m_value()));
        chk("neg",    64'(neg),    64'(m_neg));
        chk("status", 64'(status), 64'(m_status()));
        $display("cyc v=%0d cmd=%h -> value=%0d neg=%0d status=%0d", v, c, value, neg, status);
    endtask

    task automatic send(input logic [3:0] c);
        cycle(1'b1, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0);
    endtask

    int  busy_len;
    bit  saw_result;
    logic [3:0] rc;

    initial begin
        reset = 1'b1; cmd = 4'h0; cmd_valid = 1'b0;
        m_clear();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_value",  64'(value),  64'd0);
        chk("reset_neg",    64'(neg),    64'd0);
        chk("reset_status", 64'(status), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // 1 + 2 =
        send(4'd1); send(4'hA); send(4'd2); send(4'hE);
        chk("add_value",  64'(value),  64'd3);
        chk("add_status", 64'(status), 64'd3);
        chk("add_neg",    64'(neg),    64'd0);

        // 3 - 10 = -7, then an operator on a negative result is ignored
        send(4'hF);
        send(4'd3); send(4'hB); send(4'd1); send(4'd0); send(4'hE);
        chk("sub_value", 64'(value), 64'd7);
        chk("sub_neg",   64'(neg),   64'd1);
        send(4'hA);
        chk("neg_chain_status", 64'(status), 64'd3);
        chk("neg_chain_value",  64'(value),  64'd7);

        // 12 * 34 = 408 after exactly WIDTH busy cycles
        send(4'hF);
        send(4'd1); send(4'd2); send(4'hC); send(4'd3); send(4'd4); send(4'hE);
        busy_len = (status == 2'b01) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            if (status != 2'b01) break;
            idle(1);
            if (status == 2'b01) busy_len++;
        end
        chk("mul_busy_len", 64'(busy_len), 64'(W));
        chk("mul_status",   64'(status),   64'd3);
        chk("mul_value",    64'(value),    64'd408);

        // chaining: 408 + 2 = 410
        send(4'hA); send(4'd2); send(4'hE);
        chk("chain_value", 64'(value), 64'd410);

        // 99999999 + 1 overflows
        send(4'hF);
        for (int i = 0; i < 8; i++) send(4'd9);
        send(4'hA); send(4'd1); send(4'hE);
        chk("ovf_status", 64'(status), 64'd2);
        chk("ovf_value",  64'(value),  64'd0);
        send(4'd5);
        chk("err_sticky", 64'(status), 64'd2);
        send(4'hF);
        chk("clr_status", 64'(status), 64'd0);
        chk("clr_value",  64'(value),  64'd0);

        // nine digits: the ninth is dropped
        for (int d = 1; d <= 9; d++) send(4'(d));
        chk("digit_limit", 64'(value), 64'd12345678);

        // CLR aborts a multiplication in flight
        send(4'hF);
        send(4'd5); send(4'hC); send(4'd5); send(4'hE);
        idle(9);
        send(4'hF);
        chk("abort_status", 64'(status), 64'd0);
        chk("abort_value",  64'(value),  64'd0);
        saw_result = 1'b0;
        for (int i = 0; i < 35; i++) begin
            idle(1);
            if (status == 2'b11) saw_result = 1'b1;
        end
        chk("abort_no_result", 64'(saw_result), 64'd0);

        // randomized command stream against the model
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 55)      rc = 4'($urandom_range(0, 9));
            else if (r < 70) rc = 4'(10 + $urandom_range(0, 2));
            else if (r < 85) rc = 4'hE;
            else if (r < 89) rc = 4'hF;
            else             rc = 4'hD;
            cycle(($urandom_range(0, 3) != 0), rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
